// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave with fixed access latency.
// Each accepted request is answered by a one-cycle ack carrying registered read
// data and an error qualifier. All outputs are registered.
// Optional build macro DMEM_ADDR_CHECK_EN: flag misaligned or out-of-range
// addresses (err=1, rdata=0, no write). Without it, the address wraps modulo
// DEPTH words and dmem_err_o is always 0.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmem_req_i,
    input  logic [DATA_WIDTH-1:0] dmem_addr_i,
    input  logic                  dmem_we_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    output logic                  dmem_err_o
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;

    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;

    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_wdata;
    logic                  w_acc_we;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_flag;

    // Next-state and counter logic; only dmem_req_i steers the FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (dmem_req_i) begin
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept     = (r_state == ST_IDLE) && dmem_req_i;
    assign w_enter_resp = (w_state_nxt == ST_RESP);

    // With LATENCY=1 the access happens on the accepting edge, before the
    // capture registers hold the request, so IDLE uses the live inputs.
    assign w_acc_addr  = (r_state == ST_IDLE) ? dmem_addr_i  : r_addr;
    assign w_acc_wdata = (r_state == ST_IDLE) ? dmem_wdata_i : r_wdata;
    assign w_acc_we    = (r_state == ST_IDLE) ? dmem_we_i    : r_we;
    assign w_idx       = w_acc_addr[IDX_W+1:2];

`ifdef DMEM_ADDR_CHECK_EN
    assign w_flag = (|w_acc_addr[1:0]) || ((w_acc_addr >> (IDX_W + 2)) != '0);
`else
    logic w_unused_addr_bits;
    assign w_flag             = 1'b0;
    assign w_unused_addr_bits = ^{w_acc_addr[1:0], w_acc_addr[DATA_WIDTH-1:IDX_W+2]};
`endif

    // A store commits on the edge entering RESP; reset held high blocks it.
    assign w_commit = w_enter_resp && w_acc_we && !w_flag && !rst_i;

    // State register, latency counter and captured request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= dmem_addr_i;
                r_wdata <= dmem_wdata_i;
                r_we    <= dmem_we_i;
            end
        end
    end

    // Response registers: non-zero only in the single RESP cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_enter_resp;
            r_err   <= w_enter_resp && w_flag;
            r_rdata <= (w_enter_resp && !w_acc_we && !w_flag) ? r_mem[w_idx] : '0;
        end
    end

    // Word array write port.
    always_ff @(posedge clk_i) begin
        // NOTE: the array is deliberately not reset; its contents survive rst_i and map to plain RAM.
        if (w_commit) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    assign dmem_ack_o   = r_ack;
    assign dmem_err_o   = r_err;
    assign dmem_rdata_o = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the responder.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk_i;
    logic        rst_i;
    logic        dmem_req_i;
    logic [31:0] dmem_addr_i;
    logic        dmem_we_i;
    logic [31:0] dmem_wdata_i;
    logic [31:0] dmem_rdata_o;
    logic        dmem_ack_o;
    logic        dmem_err_o;

    int total = 0;
    int bad   = 0;

    dmem_responder #(
        .DATA_WIDTH(32),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dmem_req_i  (dmem_req_i),
        .dmem_addr_i (dmem_addr_i),
        .dmem_we_i   (dmem_we_i),
        .dmem_wdata_i(dmem_wdata_i),
        .dmem_rdata_o(dmem_rdata_o),
        .dmem_ack_o  (dmem_ack_o),
        .dmem_err_o  (dmem_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One request at a time: accepted at edge N when the responder is free,
    // answered in the cycle following edge N+LAT-1, free again at edge N+LAT+1.
    logic [31:0] mem_m [DEPTH];
    int          cyc        = 0;
    bit          m_busy     = 0;
    int          m_due      = 0;
    int          m_next_acc = 0;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_we;
    logic        exp_ack   = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_rdata = '0;

    function automatic bit flagged(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                m_busy     = 0;
                m_next_acc = 0;
                exp_ack    = 1'b0;
                exp_err    = 1'b0;
                exp_rdata  = '0;
            end else begin
                cyc++;
                exp_ack   = 1'b0;
                exp_err   = 1'b0;
                exp_rdata = '0;
                if (!m_busy && cyc >= m_next_acc && dmem_req_i === 1'b1) begin
                    m_busy     = 1;
                    m_addr     = dmem_addr_i;
                    m_we       = dmem_we_i;
                    m_wdata    = dmem_wdata_i;
                    m_due      = cyc + LAT - 1;
                    m_next_acc = cyc + LAT + 1;
                end
                if (m_busy && cyc == m_due) begin
                    int  idx;
                    bit  fl;
                    idx     = int'((m_addr >> 2) % DEPTH);
                    fl      = flagged(m_addr);
                    exp_ack = 1'b1;
                    exp_err = fl;
                    if (!fl && m_we) mem_m[idx] = m_wdata;
                    if (!fl && !m_we) exp_rdata = mem_m[idx];
                    m_busy = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_i) begin
        check("ack", {31'd0, dmem_ack_o}, {31'd0, exp_ack});
        check("err", {31'd0, dmem_err_o}, {31'd0, exp_err});
        check("rdata", dmem_rdata_o, exp_rdata);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
        dmem_req_i   = 1'b1;
        dmem_addr_i  = a;
        dmem_we_i    = we;
        dmem_wdata_i = wd;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (dmem_ack_o === 1'b1) begin
                lat = i;
                rd  = dmem_rdata_o;
                er  = dmem_err_o;
                break;
            end
        end
        dmem_req_i = 1'b0;
        if (lat < 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          acks;
        int          ack_at [$];

        rst_i        = 1'b1;
        dmem_req_i   = 1'b0;
        dmem_addr_i  = '0;
        dmem_we_i    = 1'b0;
        dmem_wdata_i = '0;

        // Reset then idle.
        repeat (3) tick();
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ack", {31'd0, dmem_ack_o}, 32'd0);
            check("idle_rdata", dmem_rdata_o, 32'd0);
        end

        // Store then load with fixed latency.
        issue(32'h10, 1'b1, 32'hDEADBEEF, lat, rd, er);
        check("store_lat", lat, LAT);
        check("store_rdata", rd, 32'd0);
        tick();
        issue(32'h10, 1'b0, 32'h0, lat, rd, er);
        check("load_lat", lat, LAT);
        check("load_rdata", rd, 32'hDEADBEEF);
        check("load_err", {31'd0, er}, 32'd0);

        // Give every word a known value.
        for (int w = 0; w < DEPTH; w++) begin
            issue(32'(w * 4), 1'b1, $urandom, lat, rd, er);
        end
        tick();

        // Held request: exactly 3 acks, 3 cycles apart.
        dmem_req_i  = 1'b1;
        dmem_addr_i = 32'h0;
        dmem_we_i   = 1'b0;
        acks        = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (dmem_ack_o === 1'b1) begin
                acks++;
                ack_at.push_back(i);
            end
        end
        dmem_req_i = 1'b0;
        check("held_acks", acks, 3);
        if (ack_at.size() == 3) begin
            check("held_first", ack_at[0], LAT);
            check("held_gap1", ack_at[1] - ack_at[0], LAT + 1);
            check("held_gap2", ack_at[2] - ack_at[1], LAT + 1);
        end
        repeat (LAT + 2) tick();

        // Reset while a store waits: nothing written, no ack.
        issue(32'h20, 1'b1, 32'h0BADF00D, lat, rd, er);
        tick();
        dmem_req_i   = 1'b1;
        dmem_addr_i  = 32'h20;
        dmem_we_i    = 1'b1;
        dmem_wdata_i = 32'h12345678;
        tick();
        dmem_req_i = 1'b0;
        rst_i      = 1'b1;
        check("rst_no_ack", {31'd0, dmem_ack_o}, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        issue(32'h20, 1'b0, 32'h0, lat, rd, er);
        check("rst_keep", rd, 32'h0BADF00D);

        // Top word and wrap/range boundary.
        issue(32'h0, 1'b1, 32'h11112222, lat, rd, er);
        issue(32'h3FC, 1'b1, 32'hA5A5A5A5, lat, rd, er);
        issue(32'h3FC, 1'b0, 32'h0, lat, rd, er);
        check("top_word", rd, 32'hA5A5A5A5);
        issue(32'h400, 1'b0, 32'h0, lat, rd, er);
`ifdef DMEM_ADDR_CHECK_EN
        check("range_err", {31'd0, er}, 32'd1);
        check("range_rdata", rd, 32'd0);
        // Misaligned store is flagged and leaves memory alone.
        issue(32'h10, 1'b1, 32'hCAFEF00D, lat, rd, er);
        issue(32'h13, 1'b1, 32'h1, lat, rd, er);
        check("misalign_err", {31'd0, er}, 32'd1);
        issue(32'h10, 1'b0, 32'h0, lat, rd, er);
        check("misalign_keep", rd, 32'hCAFEF00D);
`else
        check("wrap_rdata", rd, 32'h11112222);
        check("wrap_err", {31'd0, er}, 32'd0);
`endif

        // Randomized traffic, including held requests and mid-operation resets.
        for (int n = 0; n < 250; n++) begin
            int          r;
            logic [31:0] a;
            r = int'($urandom_range(0, 29));
            a = $urandom_range(0, 32'h4FF);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (r == 0) begin
                tick();
                dmem_req_i   = 1'b1;
                dmem_addr_i  = a;
                dmem_we_i    = 1'b1;
                dmem_wdata_i = $urandom;
                tick();
                dmem_req_i = 1'b0;
                repeat ($urandom_range(0, LAT - 1)) tick();
                rst_i = 1'b1;
                repeat (2) tick();
                rst_i = 1'b0;
            end else if (r < 3) begin
                dmem_req_i   = 1'b1;
                dmem_addr_i  = a;
                dmem_we_i    = 1'($urandom_range(0, 1));
                dmem_wdata_i = $urandom;
                repeat ($urandom_range(4, 10)) tick();
                dmem_req_i = 1'b0;
                repeat (LAT + 2) tick();
            end else begin
                repeat ($urandom_range(0, 2)) tick();
                issue(a, 1'($urandom_range(0, 1)), $urandom, lat, rd, er);
            end
        end

        repeat (LAT + 3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
